// File: rtl/wm_phase_timer_if.sv
// rtl/wm_phase_timer_if.sv - condition/status bundle between the washer FSM and its phase timer
//
// master: the controller side; drives run/actuator and raw sensor signals, reads conditions.
// slave : the phase timer; reads run/sensor signals, drives debounced levels, done flags,
//         fault and remaining_secs.
interface wm_phase_timer_if #(
    parameter int CNT_W = 16
);
    logic             wash_run;
    logic             spin_run;
    logic             fill_run;
    logic             level_hi_raw;
    logic             level_lo_raw;
    logic             clear_fault;
    logic             filled;
    logic             drained;
    logic             cycletime_out;
    logic             spintime_out;
    logic             fault;
    logic [CNT_W-1:0] remaining_secs;

    modport master (
        output wash_run, spin_run, fill_run, level_hi_raw, level_lo_raw, clear_fault,
        input  filled, drained, cycletime_out, spintime_out, fault, remaining_secs
    );

    modport slave (
        input  wash_run, spin_run, fill_run, level_hi_raw, level_lo_raw, clear_fault,
        output filled, drained, cycletime_out, spintime_out, fault, remaining_secs
    );
endinterface

// File: rtl/wm_phase_timer.sv
// rtl/wm_phase_timer.sv - washer phase timer: sensor debounce, wash/spin timing, fill watchdog
//
// Ports:
//   clk  - clock
//   rst  - asynchronous active-low reset
//   bus  - wm_phase_timer_if.slave
//          in : wash_run, spin_run, fill_run, level_hi_raw, level_lo_raw, clear_fault
//          out: filled, drained, cycletime_out, spintime_out, fault, remaining_secs
module wm_phase_timer #(
    parameter int CLK_PER_SEC       = 1000,
    parameter int WASH_SECS         = 20,
    parameter int SPIN_SECS         = 10,
    parameter int DEB_CYCLES        = 4,
    parameter int FILL_TIMEOUT_SECS = 60,
    parameter int CNT_W             = 16
) (
    input logic              clk,
    input logic              rst,
    wm_phase_timer_if.slave  bus
);
    localparam int PW        = $clog2(CLK_PER_SEC);
    localparam int DW        = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
    localparam int WASH_LOAD = (WASH_SECS == 0) ? 1 : WASH_SECS;
    localparam int SPIN_LOAD = (SPIN_SECS == 0) ? 1 : SPIN_SECS;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WASH,
        S_WASH_DONE,
        S_SPIN,
        S_SPIN_DONE
    } state_t;

    state_t           state, state_n;
    logic [CNT_W-1:0] count, count_n;
    logic             entry;
    logic [PW-1:0]    presc;
    logic             presc_run;
    logic             sec_tick;
    logic [CNT_W-1:0] wd_cnt;
    logic             wd_active;
    logic             fault_q;
    logic             cycletime_q;
    logic             spintime_q;
    logic             hi_s1, hi_s2, lo_s1, lo_s2;
    logic [DW-1:0]    hi_cnt, lo_cnt;
    logic             filled_q, drained_q;
    logic             timing;

    // Two-flop synchronizers for the asynchronous float switches.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hi_s1 <= 1'b0;
            hi_s2 <= 1'b0;
            lo_s1 <= 1'b0;
            lo_s2 <= 1'b0;
        end else begin
            hi_s1 <= bus.level_hi_raw;
            hi_s2 <= hi_s1;
            lo_s1 <= bus.level_lo_raw;
            lo_s2 <= lo_s1;
        end
    end

    // Debounce: the level flips on the DEB_CYCLES-th consecutive differing sample.
    // drained debounces the inverted low switch so that it reads 1 when the tub is empty.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hi_cnt    <= '0;
            filled_q  <= 1'b0;
            lo_cnt    <= '0;
            drained_q <= 1'b0;
        end else begin
            if (hi_s2 == filled_q) begin
                hi_cnt <= '0;
            end else if (hi_cnt == DW'(DEB_CYCLES - 1)) begin
                filled_q <= hi_s2;
                hi_cnt   <= '0;
            end else begin
                hi_cnt <= hi_cnt + DW'(1);
            end

            if (!lo_s2 == drained_q) begin
                lo_cnt <= '0;
            end else if (lo_cnt == DW'(DEB_CYCLES - 1)) begin
                drained_q <= !lo_s2;
                lo_cnt    <= '0;
            end else begin
                lo_cnt <= lo_cnt + DW'(1);
            end
        end
    end

    assign timing    = (state == S_WASH) || (state == S_SPIN);
    assign wd_active = bus.fill_run && !filled_q && !fault_q;
    assign presc_run = timing || wd_active;
    assign sec_tick  = presc_run && (presc == PW'(CLK_PER_SEC - 1));

    // Prescaler restarts on phase entry so the first second of a phase is a full second.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            presc <= '0;
        end else if (entry || !presc_run || sec_tick) begin
            presc <= '0;
        end else begin
            presc <= presc + PW'(1);
        end
    end

    always_comb begin
        state_n = state;
        count_n = count;
        entry   = 1'b0;
        case (state)
            S_IDLE: begin
                if (bus.wash_run) begin
                    state_n = S_WASH;
                    count_n = CNT_W'(WASH_LOAD);
                    entry   = 1'b1;
                end else if (bus.spin_run) begin
                    state_n = S_SPIN;
                    count_n = CNT_W'(SPIN_LOAD);
                    entry   = 1'b1;
                end
            end
            S_WASH: begin
                if (!bus.wash_run) begin
                    state_n = S_IDLE;
                    count_n = '0;
                end else if (sec_tick) begin
                    if (count == CNT_W'(1)) begin
                        state_n = S_WASH_DONE;
                        count_n = '0;
                    end else begin
                        count_n = count - CNT_W'(1);
                    end
                end
            end
            S_WASH_DONE: begin
                if (!bus.wash_run) state_n = S_IDLE;
            end
            S_SPIN: begin
                if (!bus.spin_run) begin
                    state_n = S_IDLE;
                    count_n = '0;
                end else if (sec_tick) begin
                    if (count == CNT_W'(1)) begin
                        state_n = S_SPIN_DONE;
                        count_n = '0;
                    end else begin
                        count_n = count - CNT_W'(1);
                    end
                end
            end
            S_SPIN_DONE: begin
                if (!bus.spin_run) state_n = S_IDLE;
            end
            default: begin
                state_n = S_IDLE;
                count_n = '0;
            end
        endcase
    end

    // Done flags decode the next state so they rise on the same edge as the transition.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= S_IDLE;
            count       <= '0;
            cycletime_q <= 1'b0;
            spintime_q  <= 1'b0;
        end else begin
            state       <= state_n;
            count       <= count_n;
            cycletime_q <= (state_n == S_WASH_DONE);
            spintime_q  <= (state_n == S_SPIN_DONE);
        end
    end

    // Fill watchdog. While the tub is still unfilled with the valve open at the limit,
    // the set term keeps re-asserting fault, so a clear only sticks once that clears.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wd_cnt  <= '0;
            fault_q <= 1'b0;
        end else begin
            if (!bus.fill_run || filled_q) begin
                wd_cnt <= '0;
            end else if (wd_active && sec_tick && (wd_cnt != '1)) begin
                wd_cnt <= wd_cnt + CNT_W'(1);
            end

            if (bus.fill_run && !filled_q && (wd_cnt == CNT_W'(FILL_TIMEOUT_SECS))) begin
                fault_q <= 1'b1;
            end else if (bus.clear_fault) begin
                fault_q <= 1'b0;
            end
        end
    end

    assign bus.filled         = filled_q;
    assign bus.drained        = drained_q;
    assign bus.cycletime_out  = cycletime_q;
    assign bus.spintime_out   = spintime_q;
    assign bus.fault          = fault_q;
    assign bus.remaining_secs = timing ? count : '0;
endmodule
